c_comment_filter: RTL



---
 rtl/c_comment_filter.sv | 111 +++++++++++
 1 files changed

// File: rtl/c_comment_filter.sv
// Strips C line and block comments from an ASCII stream while passing string literals through untouched.
// Emits one cleaned character per cycle (registered, latency 1) and counts removed comments.
module c_comment_filter #(
  parameter bit BLOCK_SPACE = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic [CNT_W-1:0] comment_cnt
);

  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_QUOTE = 8'h22;
  localparam logic [7:0] CH_BSL   = 8'h5C;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    CODE, SLASH, FLUSH, LINE, BLOCK, BSTAR, STR, STR_ESC
  } state_t;

  state_t     state;
  logic [7:0] held;
  logic       accept;

  // FLUSH spends a cycle emitting the character that followed a lone '/'.
  assign in_ready = (state != FLUSH);
  assign accept   = in_valid && in_ready;

  // NOTE: every register here, the held character included, is cleared on reset;
  // a stale held char would otherwise leak out after a mid-stream reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CODE;
      held        <= 8'h00;
      out         <= 8'h00;
      out_valid   <= 1'b0;
      comment_cnt <= '0;
    end else begin
      // NOTE: non-blocking defaults first; later assignments in this block override them.
      out       <= 8'h00;
      out_valid <= 1'b0;
      case (state)
        CODE: if (accept) begin
          if (in == CH_SLASH) begin
            state <= SLASH;
          end else begin
            out       <= in;
            out_valid <= 1'b1;
            if (in == CH_QUOTE) state <= STR;
          end
        end
        SLASH: if (accept) begin
          if (in == CH_SLASH) begin
            state <= LINE;
          end else if (in == CH_STAR) begin
            state <= BLOCK;
          end else begin
            out       <= CH_SLASH;
            out_valid <= 1'b1;
            held      <= in;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          out       <= held;
          out_valid <= 1'b1;
          state     <= (held == CH_QUOTE) ? STR : CODE;
        end
        LINE: if (accept && in == CH_NL) begin
          out       <= CH_NL;
          out_valid <= 1'b1;
          state     <= CODE;
          if (!(&comment_cnt)) comment_cnt <= comment_cnt + 1'b1;
        end
        BLOCK: if (accept && in == CH_STAR) state <= BSTAR;
        BSTAR: if (accept) begin
          if (in == CH_SLASH) begin
            state <= CODE;
            if (!(&comment_cnt)) comment_cnt <= comment_cnt + 1'b1;
            if (BLOCK_SPACE) begin
              out       <= CH_SPACE;
              out_valid <= 1'b1;
            end
          end else if (in != CH_STAR) begin
            state <= BLOCK;
          end
        end
        STR: if (accept) begin
          out       <= in;
          out_valid <= 1'b1;
          if (in == CH_BSL)        state <= STR_ESC;
          else if (in == CH_QUOTE) state <= CODE;
        end
        STR_ESC: if (accept) begin
          out       <= in;
          out_valid <= 1'b1;
          state     <= STR;
        end
        default: state <= CODE;
      endcase
    end
  end

endmodule
